// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared types and default sizes for the UART transmit arbiter.
//   - state_t       : sequencer state encoding (IDLE / START / WAIT_EOT)
//   - DATA_W        : width of one requester byte lane
//   - N_REQ_DEF     : default number of requesters
//   - TIMEOUT_CYCLES_DEF, CNT_W : defaults for the optional EOT watchdog
//                     (only used when UART_TX_ARB_TIMEOUT_EN is defined)
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    WAIT_EOT = 2'd2
  } state_t;

  localparam int DATA_W             = 8;
  localparam int N_REQ_DEF          = 4;
  localparam int TIMEOUT_CYCLES_DEF = 20000;
  localparam int CNT_W              = 32;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. Searches req_i starting one position
//   above rr_ptr_i and wrapping, and reports the first set bit.
// Ports
//   req_i        in   N_REQ   request vector
//   rr_ptr_i     in   IDX_W   index of the most recently served requester
//   grant_idx_o  out  IDX_W   chosen requester (0 when nothing is requested)
//   grant_vld_o  out  1       at least one request is set
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_vld_o
);

  int cand;

  // Walk the offsets from the farthest to the nearest so that the nearest
  // set bit above the pointer is the last one written and therefore wins.
  always_comb begin
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    cand        = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = (int'(rr_ptr_i) + k) % N_REQ;
      if (req_i[cand]) begin
        grant_idx_o = IDX_W'(cand);
        grant_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmit core between N_REQ byte requesters. A
//   requester is chosen round-robin, its byte is latched and a single-cycle
//   Tx_Start is issued; the byte is held until the core reports Tx_Eot,
//   after which the requester receives a one-cycle Ack.
//
// Optional feature (macro UART_TX_ARB_TIMEOUT_EN):
//   Adds the TIMEOUT_CYCLES parameter and a 32-bit watchdog in WAIT_EOT.
//   If Tx_Eot has not arrived after TIMEOUT_CYCLES waiting cycles the
//   transfer is abandoned with a one-cycle Timeout pulse instead of Ack.
//   Without the macro Timeout is constant 0 and WAIT_EOT waits forever.
//
// Ports
//   Clk       in   1          clock, rising edge
//   Rst_n     in   1          synchronous reset, active low
//   Req       in   N_REQ      level request per requester
//   Data      in   8*N_REQ    requester i byte at Data[8*i +: 8]
//   Ack       out  N_REQ      one-cycle pulse, byte fully transmitted
//   Timeout   out  1          one-cycle pulse, transfer abandoned
//   Busy      out  1          sequencer is not IDLE
//   Tx_Start  out  1          start pulse to the UART TX core
//   Tx_Data   out  8          byte to the UART TX core
//   Tx_Eot    in   1          end-of-transmission pulse from the core
// ----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [N_REQ-1:0]        Req,
  input  logic [DATA_W*N_REQ-1:0] Data,
  output logic [N_REQ-1:0]        Ack,
  output logic                    Timeout,
  output logic                    Busy,
  output logic                    Tx_Start,
  output logic [DATA_W-1:0]       Tx_Data,
  input  logic                    Tx_Eot
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [N_REQ-1:0]    ack_q, ack_d;

  logic [IDX_W-1:0]    arb_idx;
  logic                arb_vld;
  logic                limit_hit;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i       (Req),
    .rr_ptr_i    (rr_ptr_q),
    .grant_idx_o (arb_idx),
    .grant_vld_o (arb_vld)
  );

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q;

  // cnt_q holds the number of WAIT_EOT cycles already completed, so the
  // limit is reached during the TIMEOUT_CYCLES-th waiting cycle.
  assign limit_hit = (state_q == WAIT_EOT) && (cnt_q == TO_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == START) begin
      cnt_d = '0;
    end else if (state_q == WAIT_EOT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      // A Tx_Eot arriving in the limit cycle completes normally.
      timeout_q <= limit_hit & ~Tx_Eot;
    end
  end

  assign Timeout = timeout_q;
`else
  assign limit_hit = 1'b0;
  assign Timeout   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    tx_data_d   = tx_data_q;
    ack_d       = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_vld) begin
          grant_idx_d = arb_idx;
          tx_data_d   = Data[DATA_W*arb_idx +: DATA_W];
          state_d     = START;
        end
      end
      START: begin
        state_d = WAIT_EOT;
      end
      WAIT_EOT: begin
        if (Tx_Eot) begin
          ack_d[grant_idx_q] = 1'b1;
          rr_ptr_d           = grant_idx_q;
          state_d            = IDLE;
        end else if (limit_hit) begin
          // Abandoned transfer still advances the pointer so a stuck
          // requester cannot monopolise the transmitter.
          rr_ptr_d = grant_idx_q;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      tx_data_q   <= '0;
      ack_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      tx_data_q   <= tx_data_d;
      ack_q       <= ack_d;
    end
  end

  assign Ack      = ack_q;
  assign Busy     = (state_q != IDLE);
  assign Tx_Start = (state_q == START);
  assign Tx_Data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Drives the arbiter together with a behavioural UART TX core
//   (16 clocks per bit, 8N1) and a line monitor that decodes frames.
//   Expected grant order comes from the round-robin rule applied to the
//   request mask; expected frames come from the bytes the bench drives.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic             Clk;
  logic             Rst_n;
  logic [N-1:0]     Req;
  logic [8*N-1:0]   Data;
  logic [N-1:0]     Ack;
  logic             Timeout;
  logic             Busy;
  logic             Tx_Start;
  logic [7:0]       Tx_Data;
  logic             Tx_Eot;

  logic [7:0]       dval [N];
  logic             eot_en;
  logic             eot_inj;

  int               n_checks = 0;
  int               n_errors = 0;
  int               m_ptr    = 0;
  int               exp_acks = 0;

  assign Data = {dval[3], dval[2], dval[1], dval[0]};

  uart_tx_arbiter #(
    .N_REQ (N)
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (50)
`endif
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Req      (Req),
    .Data     (Data),
    .Ack      (Ack),
    .Timeout  (Timeout),
    .Busy     (Busy),
    .Tx_Start (Tx_Start),
    .Tx_Data  (Tx_Data),
    .Tx_Eot   (Tx_Eot)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural UART TX core: start bit, 8 data bits LSB first, stop bit.
  logic [9:0] frm_q;
  logic [3:0] bit_q;
  logic [3:0] cyc_q;
  logic       act_q;
  logic       eot_q;
  logic       tx_line;

  always @(posedge Clk) begin
    eot_q <= 1'b0;
    if (!Rst_n) begin
      act_q <= 1'b0;
      frm_q <= '1;
      bit_q <= '0;
      cyc_q <= '0;
    end else if (!act_q) begin
      if (Tx_Start) begin
        act_q <= 1'b1;
        frm_q <= {1'b1, Tx_Data, 1'b0};
        bit_q <= '0;
        cyc_q <= '0;
      end
    end else if (cyc_q == 4'd15) begin
      cyc_q <= '0;
      frm_q <= {1'b1, frm_q[9:1]};
      if (bit_q == 4'd9) begin
        act_q <= 1'b0;
        eot_q <= 1'b1;
      end else begin
        bit_q <= bit_q + 4'd1;
      end
    end else begin
      cyc_q <= cyc_q + 4'd1;
    end
  end

  assign tx_line = act_q ? frm_q[0] : 1'b1;
  assign Tx_Eot  = (eot_q & eot_en) | eot_inj;

  // Line monitor: samples mid-bit and queues complete 10-bit frames.
  logic [9:0] rx_q [$];
  logic [9:0] msh;
  logic       mon_act;
  int         mcnt;

  always @(posedge Clk) begin
    if (!Rst_n) begin
      mon_act <= 1'b0;
      mcnt    <= 0;
    end else if (!mon_act) begin
      if (!tx_line) begin
        mon_act <= 1'b1;
        mcnt    <= 0;
      end
    end else begin
      mcnt <= mcnt + 1;
      if (mcnt % 16 == 7) begin
        msh[mcnt/16] <= tx_line;
        if (mcnt / 16 == 9) begin
          mon_act <= 1'b0;
          rx_q.push_back({tx_line, msh[8:0]});
        end
      end
    end
  end

  // Sticky protocol observations, evaluated at the end of the run.
  int   ack_seen = 0;
  logic ack_bad  = 1'b0;
  logic to_seen  = 1'b0;

  always @(negedge Clk) begin
    if (Ack != '0) ack_seen <= ack_seen + 1;
    if ($countones(Ack) > 1 || (Ack != '0 && Timeout === 1'b1)) ack_bad <= 1'b1;
    if (Timeout === 1'b1) to_seen <= 1'b1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first set request strictly after the last served one.
  function automatic int model_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic xfer_start(input int idx, input int maxw);
    int w;
    w = 0;
    while (Tx_Start !== 1'b1 && w < maxw) begin
      tick();
      w++;
    end
    check("tx_start", 32'(Tx_Start), 32'd1);
    check("tx_data", 32'(Tx_Data), 32'(dval[idx]));
    check("busy_start", 32'(Busy), 32'd1);
    tick();
    check("start_width", 32'(Tx_Start), 32'd0);
  endtask

  task automatic xfer_end(input int idx, input logic [N-1:0] nxt_req, input logic [N-1:0] add);
    int w;
    logic [9:0] fr;
    w = 0;
    while (Tx_Eot !== 1'b1 && w < 400) begin
      tick();
      w++;
    end
    check("eot_seen", 32'(Tx_Eot), 32'd1);
    check("data_held", 32'(Tx_Data), 32'(dval[idx]));
    tick();
    check("ack", 32'(Ack), 32'(1 << idx));
    check("busy_ack", 32'(Busy), 32'd0);
    check("timeout_ack", 32'(Timeout), 32'd0);
    check("frame_cnt", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) begin
      fr = rx_q.pop_front();
      check("frame", 32'(fr), 32'({1'b1, dval[idx], 1'b0}));
    end
    exp_acks++;
    m_ptr = idx;
    for (int i = 0; i < N; i++) begin
      if (add[i]) dval[i] = 8'($urandom);
    end
    Req = nxt_req;
    tick();
    check("ack_width", 32'(Ack), 32'd0);
  endtask

  task automatic pulse_reset();
    Req   = '0;
    Rst_n = 1'b0;
    repeat (2) tick();
    Rst_n = 1'b1;
    m_ptr = 0;
    tick();
  endtask

  initial begin
    int idx;
    int order [4];
    logic saw;
    logic [N-1:0] add;
    logic [N-1:0] rest;

    Rst_n   = 1'b0;
    Req     = '0;
    eot_en  = 1'b1;
    eot_inj = 1'b0;
    for (int i = 0; i < N; i++) dval[i] = 8'h00;

    // 1. reset values, then a single requester
    repeat (3) tick();
    check("rst_ack", 32'(Ack), 32'd0);
    check("rst_timeout", 32'(Timeout), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_start", 32'(Tx_Start), 32'd0);
    check("rst_data", 32'(Tx_Data), 32'd0);
    Rst_n = 1'b1;
    tick();
    dval[0] = 8'hA5;
    Req = 4'b0001;
    tick();
    xfer_start(0, 0);
    xfer_end(0, 4'b0000, 4'b0000);
    repeat (3) tick();
    check("t1_idle", 32'(Busy), 32'd0);

    // 2. all four held after reset: 1,2,3,0
    pulse_reset();
    for (int i = 0; i < N; i++) dval[i] = 8'(8'h10 + i);
    order[0] = 1; order[1] = 2; order[2] = 3; order[3] = 0;
    Req = 4'b1111;
    tick();
    for (int j = 0; j < 4; j++) begin
      xfer_start(order[j], 0);
      rest = Req & ~4'(1 << order[j]);
      xfer_end(order[j], rest, 4'b0000);
    end

    // 3. requester 2 drops its request while its frame is on the line
    dval[2] = 8'h5A;
    dval[3] = 8'hC3;
    Req = 4'b1100;
    tick();
    xfer_start(2, 0);
    repeat (20) tick();
    Req = 4'b1000;
    xfer_end(2, 4'b1000, 4'b0000);
    xfer_start(3, 0);
    xfer_end(3, 4'b0000, 4'b0000);
    saw = 1'b0;
    repeat (200) begin
      tick();
      if (Tx_Start === 1'b1) saw = 1'b1;
    end
    check("t3_no_regrant", 32'(saw), 32'd0);

    // 4. one-cycle reset in the middle of a frame
    dval[0] = 8'h3C;
    Req = 4'b0001;
    tick();
    xfer_start(0, 0);
    repeat (60) tick();
    Rst_n = 1'b0;
    tick();
    check("mid_rst_ack", 32'(Ack), 32'd0);
    check("mid_rst_busy", 32'(Busy), 32'd0);
    check("mid_rst_start", 32'(Tx_Start), 32'd0);
    check("mid_rst_data", 32'(Tx_Data), 32'd0);
    check("mid_rst_timeout", 32'(Timeout), 32'd0);
    Rst_n = 1'b1;
    m_ptr = 0;
    tick();
    xfer_start(0, 0);
    xfer_end(0, 4'b0000, 4'b0000);

    // 6. stray Tx_Eot while idle
    for (int j = 0; j < 3; j++) begin
      eot_inj = 1'b1;
      tick();
      eot_inj = 1'b0;
      check("stray_eot_ack", 32'(Ack), 32'd0);
      check("stray_eot_busy", 32'(Busy), 32'd0);
      tick();
    end
    dval[1] = 8'h96;
    Req = 4'b0010;
    tick();
    xfer_start(model_pick(4'b0010, m_ptr), 0);
    xfer_end(1, 4'b0000, 4'b0000);

    // random request patterns checked against the round-robin rule
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) dval[i] = 8'($urandom);
      Req = 4'($urandom_range(1, 15));
      tick();
      while (Req != '0) begin
        idx  = model_pick(Req, m_ptr);
        xfer_start(idx, 0);
        rest = Req & ~4'(1 << idx);
        add  = ($urandom_range(0, 3) == 0) ? (4'($urandom) & ~rest) : 4'b0000;
        xfer_end(idx, rest | add, add);
      end
      repeat (3) tick();
      check("rand_idle", 32'(Busy), 32'd0);
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    // 5. watchdog: Tx_Eot suppressed, limit 50 waiting cycles
    pulse_reset();
    eot_en = 1'b0;
    dval[0] = 8'h21;
    dval[1] = 8'h42;
    Req = 4'b0011;
    tick();
    check("to_start", 32'(Tx_Start), 32'd1);
    check("to_start_data", 32'(Tx_Data), 32'(dval[model_pick(4'b0011, m_ptr)]));
    saw = 1'b0;
    repeat (50) begin
      tick();
      if (Timeout === 1'b1) saw = 1'b1;
    end
    check("to_early", 32'(saw), 32'd0);
    tick();
    check("to_pulse", 32'(Timeout), 32'd1);
    check("to_no_ack", 32'(Ack), 32'd0);
    m_ptr = 1;
    tick();
    check("to_next_start", 32'(Tx_Start), 32'd1);
    check("to_next_data", 32'(Tx_Data), 32'(dval[model_pick(4'b0011, m_ptr)]));
    check("to_width", 32'(Timeout), 32'd0);
    pulse_reset();
    eot_en = 1'b1;
    rx_q.delete();
`else
    check("timeout_tied", 32'(to_seen), 32'd0);
`endif

    repeat (2) tick();
    check("ack_count", 32'(ack_seen), 32'(exp_acks));
    check("ack_onehot", 32'(ack_bad), 32'd0);
    check("rx_leftover", 32'(rx_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
